// File: rtl/fft_frame_feeder_if.sv
// Sample-in / FFT-beat-out bundle for the frame feeder.
interface fft_frame_feeder_if #(
    parameter int unsigned SAMPLE_WIDTH = 16
);
    logic                           audio_valid_in;
    logic signed [SAMPLE_WIDTH-1:0] audio_sample_in;
    logic                           fft_ready_in;
    logic                           fft_valid_out;
    logic [47:0]                    fft_data_out;
    logic                           fft_last_out;
    logic                           frame_dropped_out;

    modport master (
        output audio_valid_in,
        output audio_sample_in,
        output fft_ready_in,
        input  fft_valid_out,
        input  fft_data_out,
        input  fft_last_out,
        input  frame_dropped_out
    );

    modport slave (
        input  audio_valid_in,
        input  audio_sample_in,
        input  fft_ready_in,
        output fft_valid_out,
        output fft_data_out,
        output fft_last_out,
        output frame_dropped_out
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer: collects FRAME_LEN audio samples into one bank while
// the other bank streams to the FFT core as complex beats (imaginary = 0).
module fft_frame_feeder #(
    parameter int unsigned FRAME_LEN    = 4096,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    fft_frame_feeder_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(FRAME_LEN);
    localparam int unsigned      HALF_W   = 24;
    localparam int unsigned      DEPTH    = 2 * FRAME_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] mem [0:DEPTH-1];
    logic [IDX_W-1:0]        wr_idx_q;
    logic                    wr_bank_q;
    logic [IDX_W-1:0]        fe_idx_q;
    logic                    fe_done_q;
    logic                    s1_valid_q;
    logic                    s1_last_q;
    logic [SAMPLE_WIDTH-1:0] s1_data_q;
    logic                    valid_q;
    logic                    last_q;
    logic [47:0]             data_q;
    logic                    dropped_q;

    logic frame_done_c;
    logic last_accept_c;
    logic out_free_c;
    logic issue_c;
    logic swap_c;
    logic drop_c;

    // Handshake and bank-control decisions for this cycle.
    assign frame_done_c  = bus.audio_valid_in && (wr_idx_q == LAST_IDX);
    assign last_accept_c = valid_q && bus.fft_ready_in && last_q;
    assign out_free_c    = !valid_q || bus.fft_ready_in;
    assign issue_c       = (state_q == STREAM) && !fe_done_q && (!s1_valid_q || out_free_c);
    assign swap_c        = frame_done_c && ((state_q == IDLE) || last_accept_c);
    assign drop_c        = frame_done_c && (state_q == STREAM) && !last_accept_c;

    // Read-side state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Read-side next state: a fresh frame starts a stream; the last beat ends it
    // unless another frame completes on that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_done_c) state_d = STREAM;
            STREAM:  if (last_accept_c && !frame_done_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample bank storage; the write bank is always the one not being read.
    always_ff @(posedge clk_in) begin
        if (!rst_in && bus.audio_valid_in)
            mem[{wr_bank_q, wr_idx_q}] <= bus.audio_sample_in;
    end

    // Write pointer and bank select.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            if (bus.audio_valid_in) wr_idx_q  <= wr_idx_q + IDX_W'(1);
            if (swap_c)             wr_bank_q <= ~wr_bank_q;
        end
    end

    // Fetch pointer into the read bank; restarts at 0 on every swap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fe_idx_q  <= '0;
            fe_done_q <= 1'b0;
        end else if (swap_c) begin
            fe_idx_q  <= '0;
            fe_done_q <= 1'b0;
        end else if (issue_c) begin
            if (fe_idx_q == LAST_IDX) fe_done_q <= 1'b1;
            else                      fe_idx_q  <= fe_idx_q + IDX_W'(1);
        end
    end

    // Registered bank read stage; holds while the output register is stalled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
        end else if (!s1_valid_q || out_free_c) begin
            s1_valid_q <= issue_c;
            if (issue_c) begin
                s1_data_q <= mem[{~wr_bank_q, fe_idx_q}];
                s1_last_q <= (fe_idx_q == LAST_IDX);
            end
        end
    end

    // Output beat register plus drop pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= drop_c;
            if (out_free_c) begin
                valid_q <= s1_valid_q;
                last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q)
                    data_q <= {HALF_W'($signed(s1_data_q)), HALF_W'(0)};
            end
        end
    end

    assign bus.fft_valid_out     = valid_q;
    assign bus.fft_data_out      = data_q;
    assign bus.fft_last_out      = last_q;
    assign bus.frame_dropped_out = dropped_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder (FRAME_LEN=8): directed literal cases plus a
// randomized run checked every cycle against a frame-level reference model.
module tb_fft_frame_feeder;
    localparam int unsigned FL = 8;
    localparam int unsigned SW = 16;

    logic clk_in;
    logic rst_in;
    int   checks;
    int   errors;
    int   drop_cnt;

    fft_frame_feeder_if #(.SAMPLE_WIDTH(SW)) bus ();

    fft_frame_feeder #(.FRAME_LEN(FL), .SAMPLE_WIDTH(SW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole frames, a beat index and the cycle streaming may start.
    logic signed [SW-1:0] wbuf  [FL];
    logic signed [SW-1:0] frame [FL];
    bit    armed = 1'b0;
    bit    have;
    bit    drop_exp;
    bit    prev_stall;
    int    beat;
    int    wcnt;
    int    cyc = 0;
    int    start_cyc;
    logic [47:0] prev_data;
    logic        prev_last;

    always @(negedge clk_in) begin
        bit exp_v, acc, last_acc, fc, had;
        exp_v = armed && have && (cyc >= start_cyc);
        if (armed) begin
            check("valid", 64'(bus.fft_valid_out), 64'(exp_v));
            check("dropped", 64'(bus.frame_dropped_out), 64'(drop_exp));
            if (exp_v) begin
                check("data", 64'(bus.fft_data_out), 64'({24'(frame[beat]), 24'h0}));
                check("last", 64'(bus.fft_last_out), 64'(beat == FL - 1));
            end
            if (prev_stall) begin
                check("hold_data", 64'(bus.fft_data_out), 64'(prev_data));
                check("hold_last", 64'(bus.fft_last_out), 64'(prev_last));
            end
            if (bus.frame_dropped_out === 1'b1) drop_cnt++;
        end
        prev_stall = armed && !rst_in && (bus.fft_valid_out === 1'b1) && !bus.fft_ready_in;
        prev_data  = bus.fft_data_out;
        prev_last  = bus.fft_last_out;
        if (rst_in) begin
            armed    = 1'b1;
            have     = 1'b0;
            wcnt     = 0;
            beat     = 0;
            drop_exp = 1'b0;
        end else if (armed) begin
            acc      = exp_v && bus.fft_ready_in;
            last_acc = acc && (beat == FL - 1);
            fc       = bus.audio_valid_in && (wcnt == FL - 1);
            had      = have;
            if (acc) beat++;
            if (last_acc) have = 1'b0;
            if (bus.audio_valid_in) begin
                wbuf[wcnt] = bus.audio_sample_in;
                wcnt = (wcnt + 1) % FL;
            end
            drop_exp = fc && had && !last_acc;
            if (fc && (!had || last_acc)) begin
                have      = 1'b1;
                beat      = 0;
                start_cyc = cyc + 3;
                for (int i = 0; i < FL; i++) frame[i] = wbuf[i];
            end
        end
        cyc++;
    end

    // All input changes happen just after a rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic write_frame(input logic [SW-1:0] s0, input int base);
        for (int i = 0; i < FL; i++) begin
            bus.audio_valid_in  = 1'b1;
            bus.audio_sample_in = (i == 0) ? s0 : SW'(base + i);
            tick();
        end
        bus.audio_valid_in = 1'b0;
    endtask

    // Expects ready=1: two idle cycles, then FL back-to-back literal beats.
    task automatic expect_stream(input int base);
        @(negedge clk_in); check("lat_c1", 64'(bus.fft_valid_out), 64'd0);
        @(negedge clk_in); check("lat_c2", 64'(bus.fft_valid_out), 64'd0);
        for (int k = 0; k < FL; k++) begin
            @(negedge clk_in);
            check("lit_valid", 64'(bus.fft_valid_out), 64'd1);
            check("lit_data", 64'(bus.fft_data_out), 64'({24'(base + k), 24'h0}));
            check("lit_last", 64'(bus.fft_last_out), 64'(k == FL - 1));
        end
        @(negedge clk_in); check("lit_idle", 64'(bus.fft_valid_out), 64'd0);
    endtask

    initial begin
        int cnt, d0, k;
        logic [3:0] pat;
        checks = 0; errors = 0; drop_cnt = 0;
        rst_in = 1'b1;
        bus.audio_valid_in = 1'b0; bus.audio_sample_in = '0; bus.fft_ready_in = 1'b1;
        repeat (3) tick();
        @(negedge clk_in);
        check("rst_valid", 64'(bus.fft_valid_out), 64'd0);
        check("rst_data", 64'(bus.fft_data_out), 64'd0);
        check("rst_last", 64'(bus.fft_last_out), 64'd0);
        check("rst_drop", 64'(bus.frame_dropped_out), 64'd0);
        tick();
        rst_in = 1'b0;

        // samples 1..8 streamed back-to-back
        write_frame(SW'(1), 1);
        expect_stream(1);

        // most negative sample sign-extends
        tick();
        write_frame(16'h8000, 100);
        repeat (3) @(negedge clk_in);
        check("neg_ext", 64'(bus.fft_data_out), 64'h0000_FF80_0000_0000);
        repeat (10) @(negedge clk_in);

        // ready pattern 1,0,0,1: 8 ordered beats, none repeated or skipped
        tick();
        write_frame(SW'(20), 20);
        pat = 4'b1001; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            bus.fft_ready_in = pat[c % 4];
            @(negedge clk_in);
            if (bus.fft_valid_out && bus.fft_ready_in) begin
                check("tog_data", 64'(bus.fft_data_out), 64'({24'(20 + cnt), 24'h0}));
                cnt++;
            end
            tick();
        end
        check("tog_beats", 64'(cnt), 64'(FL));
        bus.fft_ready_in = 1'b1;

        // second frame completes while stalled -> single drop pulse
        tick();
        bus.fft_ready_in = 1'b0;
        d0 = drop_cnt;
        write_frame(SW'(30), 30);
        write_frame(SW'(40), 40);
        repeat (3) @(negedge clk_in);
        check("drop_one", 64'(drop_cnt - d0), 64'd1);
        tick();
        bus.fft_ready_in = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (bus.fft_valid_out) begin
                check("drop_data", 64'(bus.fft_data_out), 64'({24'(30 + cnt), 24'h0}));
                cnt++;
            end
        end
        check("drop_beats", 64'(cnt), 64'(FL));

        // frame completes on the same edge the last beat is accepted
        tick();
        d0 = drop_cnt;
        write_frame(SW'(50), 50);
        tick(); tick();
        write_frame(SW'(60), 60);
        expect_stream(60);
        check("sim_nodrop", 64'(drop_cnt - d0), 64'd0);

        // reset on beat 3 aborts, fresh frame streams normally
        tick();
        write_frame(SW'(70), 70);
        k = 0;
        for (int c = 0; c < 10 && k < 2; c++) begin
            @(negedge clk_in);
            if (bus.fft_valid_out) k++;
        end
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_abort", 64'(bus.fft_valid_out), 64'd0);
        tick();
        write_frame(SW'(80), 80);
        expect_stream(80);

        // randomized traffic against the model
        tick();
        for (int c = 0; c < 3000; c++) begin
            int mode;
            mode = (c / 250) % 4;
            bus.audio_valid_in  = ($urandom_range(0, 9) < ((mode == 3) ? 3 : 9));
            bus.audio_sample_in = SW'($urandom);
            case (mode)
                0:       bus.fft_ready_in = 1'b1;
                1:       bus.fft_ready_in = ($urandom_range(0, 1) == 1);
                2:       bus.fft_ready_in = ($urandom_range(0, 9) == 0);
                default: bus.fft_ready_in = ($urandom_range(0, 3) != 0);
            endcase
            rst_in = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst_in = 1'b0; bus.audio_valid_in = 1'b0; bus.fft_ready_in = 1'b1;
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
